// File: rtl/iob_l2_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : iob_l2_arbiter
// Description : Round-robin arbiter that shares one L2 cache port between
//               N_MASTERS L1 back-ends and sequences L2 invalidation
//               (drain, wait for write buffer empty, fire force_inv).
//               Define L2ARB_FIXED_PRIO_EN for fixed lowest-index priority.
// Revision    : 1.0 - initial release
// ============================================================================
module iob_l2_arbiter #(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 24,
    parameter int DATA_W    = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_MASTERS-1:0]          m_valid,
    input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
    input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
    input  logic [N_MASTERS*DATA_W/8-1:0] m_wstrb,
    output logic [N_MASTERS*DATA_W-1:0]   m_rdata,
    output logic [N_MASTERS-1:0]          m_ready,
    output logic                          s_valid,
    output logic [ADDR_W-1:0]             s_addr,
    output logic [DATA_W-1:0]             s_wdata,
    output logic [DATA_W/8-1:0]           s_wstrb,
    input  logic [DATA_W-1:0]             s_rdata,
    input  logic                          s_ready,
    input  logic                          inv_req,
    input  logic                          wtb_empty,
    output logic                          force_inv,
    output logic                          inv_busy
);

    localparam int c_gw = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int c_pw = c_gw + 1;
    localparam int c_sw = DATA_W / 8;
    localparam logic [c_gw-1:0] c_last = c_gw'(N_MASTERS - 1);
    localparam logic [c_pw-1:0] c_n    = c_pw'(N_MASTERS);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_BUSY     = 2'd1,
        ST_INV_WAIT = 2'd2,
        ST_INV_FIRE = 2'd3
    } state_t;

    state_t                  r_state, w_state_nxt;
    logic [c_gw-1:0]         r_grant, w_grant_nxt;
    logic [c_gw-1:0]         r_rr_ptr, w_rr_ptr_nxt;
    logic                    r_inv_pending, w_inv_pending_nxt;
    logic [c_gw-1:0]         w_pick;
    logic [c_pw-1:0]         w_sum;
    logic [2*N_MASTERS-1:0]  w_rot;
    logic                    w_gvalid;
    logic                    w_busy;

    assign w_busy   = (r_state == ST_BUSY);
    assign inv_busy = r_inv_pending || (r_state == ST_INV_WAIT) || (r_state == ST_INV_FIRE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_grant       <= '0;
            r_rr_ptr      <= '0;
            r_inv_pending <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_grant       <= w_grant_nxt;
            r_rr_ptr      <= w_rr_ptr_nxt;
            r_inv_pending <= w_inv_pending_nxt;
        end
    end

    // Rotate requests so bit k is master (rr_ptr+k); the lowest set bit wins.
    // With the pointer held at zero this degenerates to fixed priority.
    always_comb begin
        w_rot  = {m_valid, m_valid} >> r_rr_ptr;
        w_pick = '0;
        w_sum  = '0;
        for (int k = N_MASTERS - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_sum = {1'b0, r_rr_ptr} + c_pw'(k);
                if (w_sum >= c_n) begin
                    w_sum = w_sum - c_n;
                end
                w_pick = w_sum[c_gw-1:0];
            end
        end
    end

    always_comb begin
        w_gvalid = 1'b0;
        s_addr   = '0;
        s_wdata  = '0;
        s_wstrb  = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (r_grant == c_gw'(i)) begin
                w_gvalid = m_valid[i];
                s_addr   = m_addr[i*ADDR_W +: ADDR_W];
                s_wdata  = m_wdata[i*DATA_W +: DATA_W];
                s_wstrb  = m_wstrb[i*c_sw +: c_sw];
            end
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_grant_nxt       = r_grant;
        w_rr_ptr_nxt      = r_rr_ptr;
        w_inv_pending_nxt = r_inv_pending || inv_req;
        s_valid           = 1'b0;
        force_inv         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_inv_pending || inv_req) begin
                    w_state_nxt = ST_INV_WAIT;
                end else if (|m_valid) begin
                    w_grant_nxt = w_pick;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                s_valid = w_gvalid;
                if (s_ready) begin
`ifdef L2ARB_FIXED_PRIO_EN
                    w_rr_ptr_nxt = '0;
`else
                    w_rr_ptr_nxt = (r_grant == c_last) ? '0 : r_grant + 1'b1;
`endif
                    w_state_nxt  = ST_IDLE;
                end
            end
            ST_INV_WAIT: begin
                if (wtb_empty) begin
                    w_state_nxt = ST_INV_FIRE;
                end
            end
            ST_INV_FIRE: begin
                // Requests arriving in this cycle are covered by this strobe.
                force_inv         = 1'b1;
                w_inv_pending_nxt = 1'b0;
                w_state_nxt       = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_rsp
        assign m_ready[gi] = w_busy && (r_grant == c_gw'(gi)) && s_ready;
        assign m_rdata[gi*DATA_W +: DATA_W] = (w_busy && (r_grant == c_gw'(gi))) ? s_rdata : '0;
    end

endmodule
`default_nettype wire

// File: tb/tb_iob_l2_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_iob_l2_arbiter
// Description : Scoreboard bench for iob_l2_arbiter with a fixed-latency L2
//               model; honours L2ARB_FIXED_PRIO_EN for grant order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iob_l2_arbiter;

    localparam int N  = 2;
    localparam int AW = 24;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      m_valid;
    logic [N*AW-1:0]   m_addr;
    logic [N*DW-1:0]   m_wdata;
    logic [N*SW-1:0]   m_wstrb;
    logic [N*DW-1:0]   m_rdata;
    logic [N-1:0]      m_ready;
    logic              s_valid;
    logic [AW-1:0]     s_addr;
    logic [DW-1:0]     s_wdata;
    logic [SW-1:0]     s_wstrb;
    logic [DW-1:0]     s_rdata;
    logic              s_ready;
    logic              inv_req;
    logic              wtb_empty;
    logic              force_inv;
    logic              inv_busy;

    logic              tb_valid [N];
    logic [AW-1:0]     tb_addr  [N];
    logic [DW-1:0]     tb_wdata [N];
    logic [SW-1:0]     tb_wstrb [N];

    typedef struct {
        int            m;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] wstrb;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t q_rsp[$];
    int   q_inv[$];
    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    bit   chk_gap  = 1'b0;
    int   last_rdy = -1;
    logic prev_sv  = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < N; g++) begin : g_drv
        assign m_valid[g]            = tb_valid[g];
        assign m_addr[g*AW +: AW]    = tb_addr[g];
        assign m_wdata[g*DW +: DW]   = tb_wdata[g];
        assign m_wstrb[g*SW +: SW]   = tb_wstrb[g];
    end

    iob_l2_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_rdata(m_rdata), .m_ready(m_ready),
        .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_rdata(s_rdata), .s_ready(s_ready),
        .inv_req(inv_req), .wtb_empty(wtb_empty),
        .force_inv(force_inv), .inv_busy(inv_busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int m, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                            input logic [SW-1:0] ws, input logic [DW-1:0] rd);
        exp_t e;
        e.m = m; e.addr = a; e.wdata = wd; e.wstrb = ws; e.rdata = rd;
        q_rsp.push_back(e);
    endtask

    task automatic drive(input int m, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input logic [SW-1:0] ws);
        tb_valid[m] = 1'b1;
        tb_addr[m]  = a;
        tb_wdata[m] = wd;
        tb_wstrb[m] = ws;
    endtask

    task automatic start_req(input int m, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                             input logic [SW-1:0] ws, input logic [DW-1:0] rd);
        push_exp(m, a, wd, ws, rd);
        drive(m, a, wd, ws);
    endtask

    task automatic finish_req(input int m, input bit drop);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!m_ready[m] && n < 100);
        checks++;
        if (!m_ready[m]) begin
            errors++;
            $display("FAIL ready_timeout m%0d: got no m_ready in %0d cycles, expected a pulse", m, n);
        end
        if (drop) begin
            @(posedge clk);
            #1;
            tb_valid[m] = 1'b0;
        end
    endtask

    task automatic wait_sv();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!s_valid && n < 50);
        checks++;
        if (!s_valid) begin
            errors++;
            $display("FAIL s_valid_timeout: got s_valid=0 for %0d cycles, expected 1", n);
        end
    endtask

    // L2 model: ready in the third cycle of a request, data derived from the address.
    initial begin
        int wc;
        bit ab;
        forever begin
            @(negedge clk);
            if (s_valid && !rst) begin
                wc = 0;
                ab = 1'b0;
                while (wc < 2 && !ab) begin
                    @(posedge clk);
                    if (rst) ab = 1'b1;
                    wc++;
                end
                if (!ab) begin
                    #1;
                    s_ready = 1'b1;
                    s_rdata = 32'hCAFE0000 | 32'(s_addr >> 8);
                    @(posedge clk);
                    #1;
                    s_ready = 1'b0;
                    s_rdata = '0;
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT completes or fires an invalidate.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (m_ready != '0) begin
                    if (q_rsp.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_ready: got m_ready=0x%0h, expected none", m_ready);
                    end else begin
                        e = q_rsp.pop_front();
                        check("grant_ready", 64'(m_ready), 64'(1) << e.m);
                        check("rdata", 64'(m_rdata[e.m*DW +: DW]), 64'(e.rdata));
                        check("s_request", {4'h0, s_addr, s_wdata, s_wstrb}, {4'h0, e.addr, e.wdata, e.wstrb});
                        for (int i = 0; i < N; i++) begin
                            if (i != e.m) check("rdata_other", 64'(m_rdata[i*DW +: DW]), 64'h0);
                        end
                    end
                    last_rdy = cyc;
                end
                if (force_inv) begin
                    if (q_inv.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_force_inv: got force_inv=1 at cycle %0d, expected 0", cyc);
                    end else begin
                        check("force_inv_cycle", 64'(cyc), 64'(q_inv.pop_front()));
                    end
                end
                if (chk_gap && s_valid && !prev_sv && last_rdy >= 0) begin
                    check("grant_bubble", 64'(cyc - last_rdy), 64'd2);
                end
                prev_sv = s_valid;
            end else begin
                prev_sv = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        inv_req   = 1'b0;
        wtb_empty = 1'b1;
        s_ready   = 1'b0;
        s_rdata   = '0;
        for (int i = 0; i < N; i++) begin
            tb_valid[i] = 1'b0; tb_addr[i] = '0; tb_wdata[i] = '0; tb_wstrb[i] = '0;
        end
        repeat (2) @(negedge clk);
        check("reset_outputs", {60'h0, s_valid, force_inv, inv_busy, |m_ready}, 64'h0);
        check("reset_rdata", 64'(m_rdata), 64'h0);
        rst = 1'b0;

        // Single read with one-cycle request latency
        @(posedge clk); #1;
        start_req(0, 24'h100, 32'h0, 4'h0, 32'hCAFE0001);
        @(negedge clk);
        check("t1_sv_cycle0", 64'(s_valid), 64'd0);
        @(negedge clk);
        check("t1_sv_cycle1", 64'(s_valid), 64'd1);
        finish_req(0, 1'b1);

        // Write routed from master 1
        @(posedge clk); #1;
        start_req(1, 24'h40, 32'hDEADBEEF, 4'hF, 32'hCAFE0000);
        finish_req(1, 1'b1);

        // Contention from reset
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        chk_gap  = 1'b1;
        last_rdy = -1;
`ifdef L2ARB_FIXED_PRIO_EN
        push_exp(0, 24'h600, 32'h0, 4'h0, 32'hCAFE0006);
        push_exp(0, 24'h700, 32'h0, 4'h0, 32'hCAFE0007);
        push_exp(1, 24'h800, 32'h0, 4'h0, 32'hCAFE0008);
        push_exp(1, 24'h900, 32'h0, 4'h0, 32'hCAFE0009);
`else
        push_exp(0, 24'h600, 32'h0, 4'h0, 32'hCAFE0006);
        push_exp(1, 24'h800, 32'h0, 4'h0, 32'hCAFE0008);
        push_exp(0, 24'h700, 32'h0, 4'h0, 32'hCAFE0007);
        push_exp(1, 24'h900, 32'h0, 4'h0, 32'hCAFE0009);
`endif
        @(posedge clk); #1;
        fork
            begin
                drive(0, 24'h600, 32'h0, 4'h0);
                finish_req(0, 1'b0);
                @(posedge clk); #1;
                drive(0, 24'h700, 32'h0, 4'h0);
                finish_req(0, 1'b1);
            end
            begin
                drive(1, 24'h800, 32'h0, 4'h0);
                finish_req(1, 1'b0);
                @(posedge clk); #1;
                drive(1, 24'h900, 32'h0, 4'h0);
                finish_req(1, 1'b1);
            end
        join
        chk_gap = 1'b0;

        // Invalidate requested mid-transaction, write buffer busy afterwards
        @(posedge clk); #1;
        wtb_empty = 1'b0;
        start_req(0, 24'h200, 32'h0, 4'h0, 32'hCAFE0002);
        wait_sv();
        @(posedge clk); #1;
        inv_req = 1'b1;
        start_req(1, 24'h300, 32'h0, 4'h0, 32'hCAFE0003);
        @(posedge clk); #1;
        inv_req = 1'b0;
        finish_req(0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_inv_busy", 64'(inv_busy), 64'd1);
            check("t4_no_grant", 64'(s_valid), 64'd0);
        end
        @(posedge clk); #1;
        wtb_empty = 1'b1;
        q_inv.push_back(cyc + 1);
        finish_req(1, 1'b1);

        // Several invalidate pulses merged into one strobe
        @(posedge clk); #1;
        wtb_empty = 1'b0;
        inv_req   = 1'b1;
        @(posedge clk); #1;
        inv_req   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1; inv_req = 1'b1;
            @(posedge clk); #1; inv_req = 1'b0;
        end
        @(negedge clk);
        check("t5_inv_busy", 64'(inv_busy), 64'd1);
        @(posedge clk); #1;
        wtb_empty = 1'b1;
        q_inv.push_back(cyc + 1);
        repeat (4) @(negedge clk);
        check("t5_inv_done", 64'(inv_busy), 64'd0);

        // Asynchronous reset while master 1 is in flight
        @(posedge clk); #1;
        start_req(0, 24'h500, 32'h0, 4'h0, 32'hCAFE0005);
        finish_req(0, 1'b1);
        @(posedge clk); #1;
        drive(1, 24'h510, 32'h0, 4'h0);
        wait_sv();
        @(posedge clk); #2;
        rst = 1'b1;
        tb_valid[1] = 1'b0;
        #1;
        check("t6_async_rst", {61'h0, s_valid, |m_ready, force_inv}, 64'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        start_req(0, 24'hA00, 32'h0, 4'h0, 32'hCAFE000A);
        start_req(1, 24'hB00, 32'h0, 4'h0, 32'hCAFE000B);
        fork
            finish_req(0, 1'b1);
            finish_req(1, 1'b1);
        join

        repeat (5) @(negedge clk);
        check("queues_empty", 64'(q_rsp.size() + q_inv.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
